sqsum_sched: RTL and testbench
==============================

Name: sqsum_sched

Overview:
- Round-robin scheduler that shares one iterative sum-of-squares engine (1²+2²+…+N²) between NREQ requesters.
- Each requester presents a 4-bit order N and holds req until acked.
- The block arbitrates, sequences the engine one term per cycle, then presents the result with the winner's id on a valid/ready output port.
- It sits between the per-channel control logic and the result consumer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- OW, 4, order width per requester.
- SW, 11, result width; must hold sum for N = 2^OW-1 (1240 for OW=4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  NREQ  request per requester; held high until corresponding ack.
- order_bus  in  NREQ*OW  order of requester i in bits [i*OW +: OW]; stable while req[i]=1.
- ack  out  NREQ  one-cycle pulse: request i accepted.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_id  out  clog2(NREQ)  requester index of current result.
- sum  out  SW  sum of k² for k=1..N of the served request.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset: everything is clocked on posedge clk; rst=1 dominates all other inputs. State=IDLE, ack=0, out_valid=0, out_id=0, sum=0, acc=0, k=0, rr_last=NREQ-1 (requester 0 has first priority).
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If req=0, stay in IDLE.
  - Otherwise the winner is the first set req bit searching from (rr_last+1) mod NREQ upward, wrapping.
  - At that edge: ord<=order of winner, cur_id<=winner, rr_last<=winner, acc<=0, k<=1, ack[winner]<=1, state<=CALC.
- ack is registered and high for exactly the first CALC cycle. The requester may drop or re-assert req from the following cycle.
- CALC, each edge:
  - If ord=0: sum<=0, state<=DONE.
  - Else: acc<=acc+k*k (product 2*OW bits, zero-extended to SW); k<=k+1.
  - When k==ord: sum<=acc+k*k, state<=DONE.
  - No wrap: k never exceeds ord.
- Latency, counted from the ack cycle: out_valid rises after max(N,1) edges. Examples: N=0 gives out_valid in the cycle after ack; N=15 gives out_valid 15 cycles after the ack cycle.
- DONE:
  - out_valid=1; out_id=cur_id; sum is stable.
  - Held indefinitely while out_ready=0. No arbitration and no ack are issued in DONE.
  - On an edge with out_ready=1: out_valid<=0, state<=IDLE. New arbitration can occur no earlier than the next edge.
- sum and out_id hold their last values after out_valid falls, until the next result.
- req bits arriving or dropping during CALC/DONE have no effect. A req dropped before ack is never granted.
- out_ready while out_valid=0 is ignored.
- Throughput per request: 1 (accept) + max(N,1) (compute) + ≥1 (DONE) cycles.
- Reset mid-CALC or mid-DONE: the in-flight result is discarded, no out_valid is produced, and rr_last returns to NREQ-1.
- busy = (state != IDLE), combinational from state.

Test Plan:
- Reset release, req=0001, order0=3, out_ready=1 -> ack=0001 for one cycle; 3 cycles later out_valid=1, sum=14, out_id=0; then out_valid=0.
- req0 with order=15, then order=0, then order=1 -> sums 1240, 0, 1; out_valid arrives 15, 1 and 1 cycles after ack respectively.
- req=1111 simultaneously, orders 1,2,3,4, requesters deassert on own ack, out_ready=1 -> grant order 0,1,2,3; sums 1,5,14,30; out_id 0,1,2,3.
- req0 and req2 re-asserted immediately after every ack, orders 2 and 5 -> grants alternate 0,2,0,2…; sums alternate 5,55; requesters 1 and 3 never acked.
- out_ready held low 6 cycles in DONE with req1 pending -> out_valid, sum, out_id constant and no ack; out_ready=1 -> next edge returns to IDLE; ack1 follows one edge later.
- rst asserted at k=4 during order-10 CALC -> next cycle all outputs at reset values and no out_valid; after release, req=1000 order 2 -> ack=1000, sum=5, out_id=3.

Source files
------------

// File: rtl/sqsum_sched.sv
// Round-robin scheduler sharing one iterative sum-of-squares engine (1^2+..+N^2) among NREQ requesters.
// Latency: ack 1 edge after grant, result max(N,1) edges after the ack cycle; result held while out_ready=0.
module sqsum_sched #(
  parameter int NREQ = 4,
  parameter int OW   = 4,
  parameter int SW   = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*OW-1:0]        order_bus,
  output logic [NREQ-1:0]           ack,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NREQ)-1:0]   out_id,
  output logic [SW-1:0]             sum,
  output logic                      busy
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_last, cur_id, win_id;
  logic            win_found;
  logic [OW-1:0]   ord, k;
  logic [SW-1:0]   acc, acc_nxt;
  logic [2*OW-1:0] sq;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(rr_last) + i) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = IW'(idx);
      end
    end
  end

  assign sq      = {{OW{1'b0}}, k} * {{OW{1'b0}}, k};
  assign acc_nxt = acc + SW'(sq);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = CALC;
      CALC:    if (ord == '0 || k == ord) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack       <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      sum       <= '0;
      acc       <= '0;
      k         <= '0;
      ord       <= '0;
      cur_id    <= '0;
      rr_last   <= IW'(NREQ - 1);
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            ord         <= order_bus[win_id*OW +: OW];
            cur_id      <= win_id;
            rr_last     <= win_id;
            acc         <= '0;
            k           <= OW'(1);
            ack[win_id] <= 1'b1;
          end
        end
        CALC: begin
          if (ord == '0) begin
            sum       <= '0;
            out_valid <= 1'b1;
            out_id    <= cur_id;
          end else begin
            acc <= acc_nxt;
            // k stops at ord so it can never wrap for the largest order.
            if (k == ord) begin
              sum       <= acc_nxt;
              out_valid <= 1'b1;
              out_id    <= cur_id;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sqsum_sched.sv
// Scoreboard bench for sqsum_sched: directed requests push expected results, a monitor checks acks and outputs.
`timescale 1ns/1ps
module tb_sqsum_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] order_bus;
  logic [3:0]  ack;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic [10:0] sum;
  logic        busy;

  sqsum_sched #(.NREQ(4), .OW(4), .SW(11)) dut (
    .clk(clk), .rst(rst), .req(req), .order_bus(order_bus), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .sum(sum), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int s;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ack_cyc = 0;
  int   grants_left [4];
  logic [3:0] prev_ack = '0;
  bit   prev_valid = 1'b0;
  bit   expect_low = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: ack pulse, result latency, result payload, valid drop after accept.
  always @(negedge clk) begin
    logic [3:0] ea;
    exp_t e;
    if (rst) begin
      prev_ack   = '0;
      prev_valid = 1'b0;
      expect_low = 1'b0;
    end else begin
      if (ack != '0) begin
        ea = '0;
        if (sb.size() != 0) ea[sb[0].id] = 1'b1;
        checks++;
        if (prev_ack != '0 || sb.size() == 0 || ack != ea) begin
          errors++;
          $display("FAIL ack_grant: got ack=%b (prev %b) expected %b", ack, prev_ack, ea);
        end
        ack_cyc = cyc;
      end
      if (expect_low) begin
        chk("out_valid_drop", int'(out_valid), 0);
        expect_low = 1'b0;
      end
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_valid_unexpected: got out_valid=1 expected no result");
        end else begin
          chk("latency", cyc - ack_cyc, sb[0].lat);
        end
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("sum", int'(sum), e.s);
        chk("out_id", int'(out_id), e.id);
        expect_low = 1'b1;
      end
      prev_ack   = ack;
      prev_valid = out_valid;
      // Requester model: hold req until the wanted number of grants is reached.
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) begin
          grants_left[i]--;
          if (grants_left[i] <= 0) req[i] = 1'b0;
        end
      end
    end
  end

  task automatic push(input int id, input int n, input int s);
    exp_t e;
    e.id  = id;
    e.s   = s;
    e.lat = (n == 0) ? 1 : n;
    sb.push_back(e);
  endtask

  task automatic start(input int id, input int n, input int times);
    order_bus[id*4 +: 4] = 4'(n);
    grants_left[id] = times;
    req[id] = 1'b1;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy || req != '0) && t < 400) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (t >= 400) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got %0d pending results expected 0", nm, sb.size());
    end
  endtask

  initial begin
    int t;
    logic [10:0] hold_sum;
    rst = 1'b1;
    req = '0;
    order_bus = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) grants_left[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", int'(ack), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_id", int'(out_id), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // Basic: order 3 -> 14
    push(0, 3, 14);  start(0, 3, 1);  drain("t1");
    // Boundary orders
    push(0, 15, 1240); start(0, 15, 1); drain("t2a");
    push(0, 0, 0);     start(0, 0, 1);  drain("t2b");
    push(0, 1, 1);     start(0, 1, 1);  drain("t2c");

    // Move the round-robin pointer to requester 3 so 0 has priority next.
    push(3, 0, 0);  start(3, 0, 1);  drain("t3pre");
    push(0, 1, 1);  push(1, 2, 5);  push(2, 3, 14);  push(3, 4, 30);
    start(0, 1, 1); start(1, 2, 1); start(2, 3, 1); start(3, 4, 1);
    drain("t3");

    // Two persistent requesters alternate.
    for (int r = 0; r < 3; r++) begin
      push(0, 2, 5);
      push(2, 5, 55);
    end
    start(0, 2, 3); start(2, 5, 3);
    drain("t4");

    // Stall in DONE with another request pending.
    out_ready = 1'b0;
    push(3, 2, 5);  start(3, 2, 1);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("t5_valid_seen", int'(out_valid), 1);
    push(1, 1, 1);  start(1, 1, 1);
    hold_sum = sum;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t5_hold_valid", int'(out_valid), 1);
      chk("t5_hold_sum", int'(sum), int'(hold_sum));
      chk("t5_hold_id", int'(out_id), 3);
      chk("t5_hold_ack", int'(ack), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_idle_valid", int'(out_valid), 0);
    chk("t5_idle_busy", int'(busy), 0);
    chk("t5_idle_ack", int'(ack), 0);
    @(negedge clk);
    chk("t5_ack1", int'(ack), 2);
    drain("t5");

    // Reset in the middle of an order-10 computation.
    push(0, 10, 385);  start(0, 10, 1);
    t = 0;
    while (!ack[0] && t < 20) begin
      @(posedge clk); #1; t++;
    end
    chk("t6_ack_seen", int'(ack), 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    req = '0;
    sb.delete();
    @(posedge clk); #1;
    chk("t6_rst_ack", int'(ack), 0);
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_sum", int'(sum), 0);
    chk("t6_rst_id", int'(out_id), 0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    push(3, 2, 5);  start(3, 2, 1);  drain("t6");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
